// File: rtl/noc_pkg.sv
// Shared NoC/GIN definitions: tag widths, PE array dimensions and GIN stage state.
package noc_pkg;
    localparam int unsigned GIN_DATA_WIDTH    = 64;
    localparam int unsigned GIN_ROW_TAG_WIDTH = 4;
    localparam int unsigned GIN_COL_TAG_WIDTH = 4;
    localparam int unsigned GIN_NUM_ROWS      = 12;
    localparam int unsigned GIN_NUM_COLS      = 14;
    localparam int unsigned GIN_COUNT_WIDTH   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gin_state_e;
endpackage

// File: rtl/gin_tag_match.sv
// Combinational row/column tag match producing the per-PE multicast target mask.
module gin_tag_match
    import noc_pkg::*;
#(
    parameter int unsigned ROW_TAG_WIDTH = GIN_ROW_TAG_WIDTH,
    parameter int unsigned COL_TAG_WIDTH = GIN_COL_TAG_WIDTH,
    parameter int unsigned NUM_ROWS      = GIN_NUM_ROWS,
    parameter int unsigned NUM_COLS      = GIN_NUM_COLS
) (
    input  logic [NUM_ROWS*ROW_TAG_WIDTH-1:0]          row_ids,
    input  logic [NUM_ROWS*NUM_COLS*COL_TAG_WIDTH-1:0] col_ids,
    input  logic [ROW_TAG_WIDTH-1:0]                   row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                   col_tag,
    output logic [NUM_ROWS*NUM_COLS-1:0]               mask
);
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        logic row_hit;
        assign row_hit = (row_ids[i*ROW_TAG_WIDTH +: ROW_TAG_WIDTH] == row_tag);
        for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
            assign mask[i*NUM_COLS+j] = row_hit &&
                (col_ids[(i*NUM_COLS+j)*COL_TAG_WIDTH +: COL_TAG_WIDTH] == col_tag);
        end
    end
endmodule

// File: rtl/filter_gin_multicast.sv
// Filter GIN multicast stage: pops word+tags, holds it until every targeted PE
// is ready at once, and counts deliveries (fires and misses) toward a programmed total.
module filter_gin_multicast
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = GIN_DATA_WIDTH,
    parameter int unsigned ROW_TAG_WIDTH = GIN_ROW_TAG_WIDTH,
    parameter int unsigned COL_TAG_WIDTH = GIN_COL_TAG_WIDTH,
    parameter int unsigned NUM_ROWS      = GIN_NUM_ROWS,
    parameter int unsigned NUM_COLS      = GIN_NUM_COLS,
    parameter int unsigned COUNT_WIDTH   = GIN_COUNT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [COUNT_WIDTH-1:0]                     total,
    output logic                                       done,
    input  logic [NUM_ROWS*ROW_TAG_WIDTH-1:0]          row_ids,
    input  logic [NUM_ROWS*NUM_COLS*COL_TAG_WIDTH-1:0] col_ids,
    input  logic                                       gin_fifo_empty,
    output logic                                       re_from_gin_fifo,
    input  logic [DATA_WIDTH-1:0]                      gin_data,
    input  logic                                       tags_fifo_empty,
    output logic                                       re_from_tags_fifo,
    input  logic [ROW_TAG_WIDTH-1:0]                   row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                   col_tag,
    output logic [DATA_WIDTH-1:0]                      pe_data,
    output logic [NUM_ROWS*NUM_COLS-1:0]               pe_valid,
    input  logic [NUM_ROWS*NUM_COLS-1:0]               pe_ready,
    output logic                                       miss
);
    localparam int unsigned NUM_PES   = NUM_ROWS * NUM_COLS;
    localparam int unsigned CNT_EXT_W = COUNT_WIDTH + 1;

    logic [NUM_PES-1:0]     match_mask_c;
    gin_state_e             state_q, state_d;
    logic                   held_q, held_d;
    logic [NUM_PES-1:0]     mask_q, mask_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] total_q, total_d;
    logic                   done_q, done_d;
    logic                   miss_q, miss_d;
    logic                   pend_q, pend_d;
    logic                   fire_c, pop_c, drop_c;
    logic [1:0]             inc_c;
    logic [CNT_EXT_W-1:0]   sum_c;

    gin_tag_match #(
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH),
        .NUM_ROWS      (NUM_ROWS),
        .NUM_COLS      (NUM_COLS)
    ) u_tag_match (
        .row_ids (row_ids),
        .col_ids (col_ids),
        .row_tag (row_tag),
        .col_tag (col_tag),
        .mask    (match_mask_c)
    );

    // All-or-nothing delivery: fire only when every targeted PE is ready.
    assign fire_c = held_q && ((pe_ready & mask_q) == mask_q);
    assign pop_c  = (state_q == RUN) && !gin_fifo_empty && !tags_fifo_empty &&
                    (!held_q || fire_c);
    assign drop_c = pop_c && (match_mask_c == '0);
    assign inc_c  = {1'b0, fire_c} + {1'b0, drop_c};
    assign sum_c  = {1'b0, count_q} + CNT_EXT_W'(inc_c);

    assign re_from_gin_fifo  = pop_c;
    assign re_from_tags_fifo = pop_c;
    assign pe_valid          = held_q ? mask_q : '0;
    assign pe_data           = data_q;
    assign done              = done_q;
    assign miss              = miss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pend_q marks a run that hit its total with a word still held; done waits for its fire.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        mask_d  = mask_q;
        data_d  = data_q;
        count_d = count_q;
        total_d = total_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        miss_d  = drop_c;

        if (fire_c) begin
            held_d = 1'b0;
        end
        if (pop_c && !drop_c) begin
            held_d = 1'b1;
            mask_d = match_mask_c;
            data_d = gin_data;
        end

        if (start) begin
            count_d = '0;
            total_d = total;
            pend_d  = 1'b0;
            if (total == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
        end else begin
            count_d = sum_c[COUNT_WIDTH-1:0];
            case (state_q)
                RUN: begin
                    if (sum_c >= {1'b0, total_q}) begin
                        state_d = IDLE;
                        if (held_d) begin
                            pend_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (pend_q && fire_c) begin
                        done_d = 1'b1;
                        pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q  <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            total_q <= '0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            held_q  <= held_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            count_q <= count_d;
            total_q <= total_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: doc/filter_gin_multicast.md
# filter_gin_multicast

Filter global-input-network (GIN) multicast stage, directly downstream of the filter NoC controller. Pops one 64-bit filter word plus its row/column tag pair from the controller's GIN and tag FIFOs. Matches the tags against per-row and per-PE ID registers and delivers the word to every matching PE in the array in a single all-ready multicast transfer. Counts completed deliveries and signals `done` when a programmed total has been delivered.

## Interface
- `DATA_WIDTH`, 64, filter word width (equals the controller's FIFO output width)
- `ROW_TAG_WIDTH`, 4, row tag / row ID width
- `COL_TAG_WIDTH`, 4, column tag / PE column ID width
- `NUM_ROWS`, 12, PE array rows
- `NUM_COLS`, 14, PE array columns
- `COUNT_WIDTH`, 16, delivered-word counter width

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse; clears counter, arms `done`.
- `total` in COUNT_WIDTH: words to deliver; sampled on `start`.
- `done` out 1: one-cycle pulse when the count reaches `total`.
- `row_ids` in NUM_ROWS*ROW_TAG_WIDTH: row i ID at slice i; static while busy.
- `col_ids` in NUM_ROWS*NUM_COLS*COL_TAG_WIDTH: PE (i,j) ID at slice i*NUM_COLS+j; static while busy.
- `gin_fifo_empty` in 1; `re_from_gin_fifo` out 1; `gin_data` in DATA_WIDTH: first-word-fall-through, data valid whenever not empty.
- `tags_fifo_empty` in 1; `re_from_tags_fifo` out 1; `row_tag` in ROW_TAG_WIDTH; `col_tag` in COL_TAG_WIDTH: FWFT.
- `pe_data` out DATA_WIDTH: broadcast to all PEs.
- `pe_valid` out NUM_ROWS*NUM_COLS: per-PE valid, bit i*NUM_COLS+j.
- `pe_ready` in NUM_ROWS*NUM_COLS: per-PE ready.
- `miss` out 1: one-cycle pulse when a popped tag pair matched no PE.

## Operation
- Target mask: bit (i,j) = (`row_ids[i]==row_tag`) & (`col_ids[i,j]==col_tag`). Purely combinational on the FIFO heads.
- States:
  - IDLE: after reset or `done`.
  - RUN: after `start`.
- Output stage is a one-entry holding register `{data, mask}` with flag `held`.
- Pop: `re_from_gin_fifo = re_from_tags_fifo = RUN & ~gin_fifo_empty & ~tags_fifo_empty & (~held | fire)`. Both FIFOs always pop together.
- `pe_valid = held ? mask : 0`. `fire = held & ((pe_ready & mask) == mask)`, i.e. every targeted PE is ready in the same cycle. Partial delivery is never allowed.
- On pop with a non-zero mask: load register, `held`=1.
- On pop with a zero mask: word is dropped and `miss` pulses. The drop counts toward `total`. `held` clears if `fire` occurred that cycle.
- Counter increments on each `fire` and on each miss. Both can occur in one cycle: +2.
- When counter+increment ≥ `total`: pulse `done`, go to IDLE. A word still held is finished first; `done` is then issued on its `fire`.
- `total`=0 on `start`: `done` pulses the next cycle, nothing pops.
- `start` while RUN: restarts the counter. The held word is kept and still delivered.

## Timing
- Reset values: `done`=0, `miss`=0, `re_*`=0, `pe_valid`=0, `pe_data`=0, counter=0, state IDLE.
- Pop at edge N → `pe_valid` asserted from cycle N+1.
- Back-to-back throughput: one word per cycle while all targets stay ready (pop and `fire` in the same cycle).
- `miss` and `done` are registered pulses, asserted the cycle after the causing edge.
- Reset asserted mid-transfer: the held word is lost and all outputs return to reset values immediately.

## Structure
- Package `noc_pkg`: shared tag widths, array dimensions, and the state enum `{IDLE, RUN}`.
- Sub-module `gin_tag_match` holds the combinational mask generation, reusable by ifmap and psum GINs.
- Top level holds the FSM, holding register, and counter.

## Test plan
- Tags (2,3), row_ids[2]=2, col_ids[2,5]=3, all ready → only `pe_valid` bit 2*14+5 high for one cycle, counter=1.
- Row tag matches all 12 rows, col tag matches column 0; PE (7,0) ready low for 4 cycles → `pe_valid` held 5 cycles, no pop during stall, single `fire`.
- Tag pair (15,15) matching nothing → `miss` pulse, both FIFOs popped once, no `pe_valid`.
- `total`=8, 8 matching words queued, all ready → 8 consecutive cycles of `fire`, `done` pulse one cycle after the 8th, state IDLE, no further pops.
- `total`=0 → `done` the cycle after `start`, zero pops.
- Reset pulled low while `held`=1 → `pe_valid`=0 asynchronously; after release the block stays IDLE until `start`.
